store_drain_queue: RTL and testbench
====================================

# store_drain_queue

Multi-entry store queue sitting downstream of the cache write-buffer register: accepts registered store hits (way select, byte enables, index, offset, data), holds them in FIFO order, and drains them into the cache data-RAM write port whenever the RAM is not busy with a read or refill. Provides same-cycle byte-granular forwarding to loads that hit a pending store, coalesces back-to-back stores to the same word, and reports empty for refill/flush sequencing.

## Interface
- OFFSET_LOG, 2, word-offset width within a line
- INDEX_LOG, 8, set-index width
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- push_en_i  in  1  store entry valid this cycle
- push_way_i  in  2  one-hot way select
- push_wen_i  in  4  byte enables
- push_index_i  in  INDEX_LOG  set index
- push_offset_i  in  OFFSET_LOG  word offset
- push_wdata_i  in  32  store data
- full_o  out  1  no free entry; upstream must stall
- empty_o  out  1  queue empty and no RAM write in flight
- ram_busy_i  in  1  data-RAM port owned by read/refill this cycle
- ram_en_o, ram_way_o(2), ram_wen_o(4), ram_index_o, ram_offset_o, ram_wdata_o(32)  out  registered data-RAM write command
- lk_way_i  in  2  load way (one-hot)
- lk_index_i  in  INDEX_LOG  load index
- lk_offset_i  in  OFFSET_LOG  load offset
- fwd_mask_o  out  4  bytes supplied by queue (combinational)
- fwd_data_o  out  32  forwarded bytes; unmasked bytes 0

## Operation
- Storage: DEPTH entries {way, wen, index, offset, data}, head/tail pointers log2(DEPTH) bits wrapping modulo DEPTH, count log2(DEPTH)+1 bits.
- Match key: way & index & offset equal.
- Push (push_en_i=1): if count≥1, tail-1 entry matches, and that entry is not popped this cycle → coalesce: per byte with push_wen_i set, overwrite data byte; wen |= push_wen_i; count unchanged. Else if ~full_o → write at tail, tail+1, count+1. Else ignored (protocol violation; assertion).
- Pop: when count≥1 and ~ram_busy_i, head entry loaded into ram_* registers, ram_en_o=1, head+1, count−1. Otherwise ram_en_o=0 next cycle (other ram_* hold).
- Simultaneous push and pop: both apply; count unchanged; full_o evaluated on pre-edge count, so push while full is ignored even if a pop occurs.
- Forwarding: candidates are the in-flight ram_* command (oldest, if ram_en_o) then queue entries head→tail; per byte, youngest matching candidate with that wen bit wins. fwd_mask_o = OR of matching wen bits.
- full_o = (count==DEPTH); empty_o = (count==0) & ~ram_en_o.
- Reset (any time, including mid-drain): pointers, count, ram_en_o, all ram_* outputs cleared to 0; queued stores discarded; full_o=0, empty_o=1.

## Timing
- Push at edge N → entry visible to forwarding in cycle N+1.
- Earliest RAM write: pop at edge N+1 (if ~ram_busy_i) → ram_en_o high in cycle N+1..N+2 window, i.e. 2 edges after push.
- Throughput: one pop per non-busy cycle; ram_busy_i high stalls drain indefinitely with no loss.
- Forwarding is purely combinational from lk_* and state; zero-cycle.
- full_o/empty_o are functions of registered state only (no combinational path from inputs).

## Structure
- Shared cache package: entry record typedef (way, wen, index, offset, data) parameterised by INDEX_LOG/OFFSET_LOG, and byte-merge function (old, new, wen).
- One sub-module: store_fwd_merge — combinational priority byte merge over DEPTH+1 candidates producing fwd_mask_o/fwd_data_o.

## Test plan
- Reset then single push (way 01, idx 0x10, off 1, wen F, data 0xDEADBEEF), ram_busy_i=0 → ram_en_o=1 two edges later with same fields; empty_o returns 1 after.
- Fill 4 distinct stores with ram_busy_i=1 → full_o=1; 5th push ignored; release busy → 4 writes in order on consecutive cycles.
- Push wen 0011 data 0x0000AAAA then same key wen 1100 data 0xBBBB0000 while busy → one entry, drained as wen F data 0xBBBBAAAA.
- Two queued stores to same key (wen 0001 data 0x11, then wen 0001 data 0x22, separated by other-key store) → lookup gives fwd_mask_o 0001, fwd_data_o 0x00000022.
- Push and pop same cycle with count=2 → count stays 2, order preserved; push at count=4 with pop → push dropped.
- Assert resetn low mid-drain with 3 entries → ram_en_o=0, empty_o=1 immediately; no further writes after release.

Source files
------------

// File: rtl/store_drain_queue_pkg.sv
// Shared definitions for the store drain queue: fixed field widths and the
// byte-granular merge used both for coalescing and for load forwarding.
package store_drain_queue_pkg;

  localparam int WAY_W  = 2;
  localparam int WEN_W  = 4;
  localparam int DATA_W = 32;

  // Bytes whose enable bit is set come from new_data, all others from old_data.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_data,
    input logic [DATA_W-1:0] new_data,
    input logic [WEN_W-1:0]  wen
  );
    logic [DATA_W-1:0] merged;
    merged = old_data;
    for (int b = 0; b < WEN_W; b++) begin
      if (wen[b]) merged[8*b +: 8] = new_data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/store_fwd_merge.sv
// Combinational forwarding merge. Candidates arrive ordered oldest (index 0)
// to youngest, so a later matching candidate overrides earlier bytes.
module store_fwd_merge
  import store_drain_queue_pkg::*;
#(
  parameter int N_CAND     = 5,
  parameter int INDEX_LOG  = 8,
  parameter int OFFSET_LOG = 2
) (
  input  logic                  cand_valid_i  [N_CAND],
  input  logic [WAY_W-1:0]      cand_way_i    [N_CAND],
  input  logic [WEN_W-1:0]      cand_wen_i    [N_CAND],
  input  logic [INDEX_LOG-1:0]  cand_index_i  [N_CAND],
  input  logic [OFFSET_LOG-1:0] cand_offset_i [N_CAND],
  input  logic [DATA_W-1:0]     cand_data_i   [N_CAND],
  input  logic [WAY_W-1:0]      lk_way_i,
  input  logic [INDEX_LOG-1:0]  lk_index_i,
  input  logic [OFFSET_LOG-1:0] lk_offset_i,
  output logic [WEN_W-1:0]      fwd_mask_o,
  output logic [DATA_W-1:0]     fwd_data_o
);

  logic [WEN_W-1:0]  w_mask;
  logic [DATA_W-1:0] w_data;

  // Walk candidates oldest to youngest so the youngest writer of each byte wins.
  always_comb begin
    // NOTE: defaults assigned first so no path leaves a variable unassigned (no latch).
    w_mask = '0;
    w_data = '0;
    for (int c = 0; c < N_CAND; c++) begin
      if (cand_valid_i[c] && cand_way_i[c] == lk_way_i &&
          cand_index_i[c] == lk_index_i && cand_offset_i[c] == lk_offset_i) begin
        w_data = byte_merge(w_data, cand_data_i[c], cand_wen_i[c]);
        w_mask = w_mask | cand_wen_i[c];
      end
    end
  end

  assign fwd_mask_o = w_mask;
  assign fwd_data_o = w_data;

endmodule

// File: rtl/store_drain_queue.sv
// FIFO of store hits between the write-buffer register and the data-RAM write
// port. Drains one entry per cycle the RAM is free, coalesces a store into the
// youngest entry when the word matches, and forwards pending bytes to loads.
module store_drain_queue
  import store_drain_queue_pkg::*;
#(
  parameter int OFFSET_LOG = 2,
  parameter int INDEX_LOG  = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push_en_i,
  input  logic [WAY_W-1:0]      push_way_i,
  input  logic [WEN_W-1:0]      push_wen_i,
  input  logic [INDEX_LOG-1:0]  push_index_i,
  input  logic [OFFSET_LOG-1:0] push_offset_i,
  input  logic [DATA_W-1:0]     push_wdata_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic                  ram_busy_i,
  output logic                  ram_en_o,
  output logic [WAY_W-1:0]      ram_way_o,
  output logic [WEN_W-1:0]      ram_wen_o,
  output logic [INDEX_LOG-1:0]  ram_index_o,
  output logic [OFFSET_LOG-1:0] ram_offset_o,
  output logic [DATA_W-1:0]     ram_wdata_o,
  input  logic [WAY_W-1:0]      lk_way_i,
  input  logic [INDEX_LOG-1:0]  lk_index_i,
  input  logic [OFFSET_LOG-1:0] lk_offset_i,
  output logic [WEN_W-1:0]      fwd_mask_o,
  output logic [DATA_W-1:0]     fwd_data_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int N_CAND = DEPTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [WAY_W-1:0]      way;
    logic [WEN_W-1:0]      wen;
    logic [INDEX_LOG-1:0]  index;
    logic [OFFSET_LOG-1:0] offset;
    logic [DATA_W-1:0]     data;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_ram_en;
  entry_t            r_ram_cmd;

  logic              w_full;
  logic              w_pop;
  logic [PTR_W-1:0]  w_last;
  logic              w_last_match;
  logic              w_coalesce;
  logic              w_write;
  entry_t            w_push;

  assign w_push = '{way: push_way_i, wen: push_wen_i, index: push_index_i,
                    offset: push_offset_i, data: push_wdata_i};

  assign w_full       = (r_count == FULL_CNT);
  assign w_pop        = (r_count != '0) && !ram_busy_i;
  assign w_last       = r_tail - 1'b1;
  assign w_last_match = (r_mem[w_last].way == push_way_i) &&
                        (r_mem[w_last].index == push_index_i) &&
                        (r_mem[w_last].offset == push_offset_i);
  // The youngest entry cannot absorb a store in the cycle it leaves for the RAM.
  assign w_coalesce   = push_en_i && (r_count != '0) && w_last_match &&
                        !(w_pop && r_count == CNT_W'(1));
  // A push arriving while full without coalescing is a protocol violation and is dropped.
  assign w_write      = push_en_i && !w_coalesce && !w_full;

  // Entry storage: coalesce into the youngest entry or append at the tail.
  // NOTE: storage is not reset; validity comes solely from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_coalesce) begin
      r_mem[w_last].data <= byte_merge(r_mem[w_last].data, push_wdata_i, push_wen_i);
      r_mem[w_last].wen  <= r_mem[w_last].wen | push_wen_i;
    end else if (w_write) begin
      r_mem[r_tail] <= w_push;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)   r_head <= r_head + 1'b1;
      if (w_write) r_tail <= r_tail + 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered RAM write command; fields hold when no entry is drained.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ram_en  <= 1'b0;
      r_ram_cmd <= '0;
    end else begin
      r_ram_en <= w_pop;
      if (w_pop) r_ram_cmd <= r_mem[r_head];
    end
  end

  assign full_o       = w_full;
  assign empty_o      = (r_count == '0) && !r_ram_en;
  assign ram_en_o     = r_ram_en;
  assign ram_way_o    = r_ram_cmd.way;
  assign ram_wen_o    = r_ram_cmd.wen;
  assign ram_index_o  = r_ram_cmd.index;
  assign ram_offset_o = r_ram_cmd.offset;
  assign ram_wdata_o  = r_ram_cmd.data;

  logic                  w_cand_valid  [N_CAND];
  logic [WAY_W-1:0]      w_cand_way    [N_CAND];
  logic [WEN_W-1:0]      w_cand_wen    [N_CAND];
  logic [INDEX_LOG-1:0]  w_cand_index  [N_CAND];
  logic [OFFSET_LOG-1:0] w_cand_offset [N_CAND];
  logic [DATA_W-1:0]     w_cand_data   [N_CAND];

  // Order forwarding candidates oldest first: in-flight RAM command, then head to tail.
  always_comb begin
    entry_t e;
    w_cand_valid[0]  = r_ram_en;
    w_cand_way[0]    = r_ram_cmd.way;
    w_cand_wen[0]    = r_ram_cmd.wen;
    w_cand_index[0]  = r_ram_cmd.index;
    w_cand_offset[0] = r_ram_cmd.offset;
    w_cand_data[0]   = r_ram_cmd.data;
    for (int i = 0; i < DEPTH; i++) begin
      e                    = r_mem[r_head + PTR_W'(i)];
      w_cand_valid[i+1]    = (CNT_W'(i) < r_count);
      w_cand_way[i+1]      = e.way;
      w_cand_wen[i+1]      = e.wen;
      w_cand_index[i+1]    = e.index;
      w_cand_offset[i+1]   = e.offset;
      w_cand_data[i+1]     = e.data;
    end
  end

  store_fwd_merge #(
    .N_CAND    (N_CAND),
    .INDEX_LOG (INDEX_LOG),
    .OFFSET_LOG(OFFSET_LOG)
  ) u_fwd_merge (
    .cand_valid_i (w_cand_valid),
    .cand_way_i   (w_cand_way),
    .cand_wen_i   (w_cand_wen),
    .cand_index_i (w_cand_index),
    .cand_offset_i(w_cand_offset),
    .cand_data_i  (w_cand_data),
    .lk_way_i     (lk_way_i),
    .lk_index_i   (lk_index_i),
    .lk_offset_i  (lk_offset_i),
    .fwd_mask_o   (fwd_mask_o),
    .fwd_data_o   (fwd_data_o)
  );

endmodule

// File: tb/tb_store_drain_queue.sv
// Self-checking bench for store_drain_queue: a behavioural queue model feeds
// a scoreboard of expected RAM writes, plus a table of forwarding lookups and
// hand-written sequences for coalescing, full, and mid-drain reset.
module tb_store_drain_queue;

  logic        clk;
  logic        resetn;
  logic        push_en_i;
  logic [1:0]  push_way_i;
  logic [3:0]  push_wen_i;
  logic [7:0]  push_index_i;
  logic [1:0]  push_offset_i;
  logic [31:0] push_wdata_i;
  logic        full_o;
  logic        empty_o;
  logic        ram_busy_i;
  logic        ram_en_o;
  logic [1:0]  ram_way_o;
  logic [3:0]  ram_wen_o;
  logic [7:0]  ram_index_o;
  logic [1:0]  ram_offset_o;
  logic [31:0] ram_wdata_o;
  logic [1:0]  lk_way_i;
  logic [7:0]  lk_index_i;
  logic [1:0]  lk_offset_i;
  logic [3:0]  fwd_mask_o;
  logic [31:0] fwd_data_o;

  store_drain_queue #(.OFFSET_LOG(2), .INDEX_LOG(8), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .push_en_i(push_en_i), .push_way_i(push_way_i), .push_wen_i(push_wen_i),
    .push_index_i(push_index_i), .push_offset_i(push_offset_i), .push_wdata_i(push_wdata_i),
    .full_o(full_o), .empty_o(empty_o), .ram_busy_i(ram_busy_i),
    .ram_en_o(ram_en_o), .ram_way_o(ram_way_o), .ram_wen_o(ram_wen_o),
    .ram_index_o(ram_index_o), .ram_offset_o(ram_offset_o), .ram_wdata_o(ram_wdata_o),
    .lk_way_i(lk_way_i), .lk_index_i(lk_index_i), .lk_offset_i(lk_offset_i),
    .fwd_mask_o(fwd_mask_o), .fwd_data_o(fwd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  way;
    logic [3:0]  wen;
    logic [7:0]  index;
    logic [1:0]  offset;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [1:0]  way;
    logic [7:0]  index;
    logic [1:0]  offset;
    logic [3:0]  mask;
    logic [31:0] data;
  } fwd_vec_t;

  ent_t mq[$];      // model of queued stores, oldest first
  ent_t exp_q[$];   // scoreboard of expected RAM write commands
  bit   m_ram_en;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit key_eq(input ent_t a, input ent_t b);
    return a.way == b.way && a.index == b.index && a.offset == b.offset;
  endfunction

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit pe, input logic [1:0] way, input logic [3:0] wen,
                       input logic [7:0] idx, input logic [1:0] off,
                       input logic [31:0] d, input bit busy);
    ent_t ne, e;
    bit   pop, full, coal;
    int   n;
    push_en_i = pe; push_way_i = way; push_wen_i = wen;
    push_index_i = idx; push_offset_i = off; push_wdata_i = d;
    ram_busy_i = busy;
    ne   = '{way: way, wen: wen, index: idx, offset: off, data: d};
    n    = mq.size();
    pop  = (n > 0) && !busy;
    full = (n == 4);
    coal = pe && (n > 0) && key_eq(mq[n-1], ne) && !(pop && n == 1);
    if (coal) begin
      for (int b = 0; b < 4; b++)
        if (wen[b]) mq[n-1].data[8*b +: 8] = d[8*b +: 8];
      mq[n-1].wen = mq[n-1].wen | wen;
    end
    if (pop) exp_q.push_back(mq.pop_front());
    if (pe && !coal && !full) mq.push_back(ne);
    m_ram_en = pop;
    @(posedge clk);
    #1;
    push_en_i = 1'b0;
    check("ram_en", 64'(ram_en_o), 64'(m_ram_en));
    if (m_ram_en) begin
      e = exp_q.pop_front();
      check("ram_cmd", {16'h0, ram_way_o, ram_wen_o, ram_index_o, ram_offset_o, ram_wdata_o},
                       {16'h0, e.way, e.wen, e.index, e.offset, e.data});
    end
    check("full", 64'(full_o), 64'(mq.size() == 4));
    check("empty", 64'(empty_o), 64'(mq.size() == 0 && !m_ram_en));
  endtask

  task automatic idle(input bit busy);
    cycle(1'b0, 2'b00, 4'h0, 8'h00, 2'd0, 32'h0, busy);
  endtask

  task automatic fwd(input string name, input logic [1:0] way, input logic [7:0] idx,
                     input logic [1:0] off, input logic [3:0] mask, input logic [31:0] data);
    lk_way_i = way; lk_index_i = idx; lk_offset_i = off;
    #1;
    check({name, "_mask"}, 64'(fwd_mask_o), 64'(mask));
    check({name, "_data"}, 64'(fwd_data_o), 64'(data));
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ram_en = 1'b0;
  endtask

  fwd_vec_t vt[6];

  initial begin
    vt[0] = '{way: 2'b01, index: 8'h20, offset: 2'd0, mask: 4'b0001, data: 32'h0000_0022};
    vt[1] = '{way: 2'b10, index: 8'h20, offset: 2'd0, mask: 4'b1111, data: 32'hCAFE_F00D};
    vt[2] = '{way: 2'b01, index: 8'h20, offset: 2'd1, mask: 4'b0000, data: 32'h0000_0000};
    vt[3] = '{way: 2'b01, index: 8'h21, offset: 2'd0, mask: 4'b0000, data: 32'h0000_0000};
    vt[4] = '{way: 2'b10, index: 8'h20, offset: 2'd3, mask: 4'b0000, data: 32'h0000_0000};
    vt[5] = '{way: 2'b01, index: 8'h44, offset: 2'd2, mask: 4'b0110, data: 32'h0077_6600};

    push_en_i = 0; push_way_i = 0; push_wen_i = 0; push_index_i = 0;
    push_offset_i = 0; push_wdata_i = 0; ram_busy_i = 0;
    lk_way_i = 0; lk_index_i = 0; lk_offset_i = 0;
    model_reset();

    // Reset state
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_en", 64'(ram_en_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_ram_cmd", {ram_way_o, ram_wen_o, ram_index_o, ram_offset_o, ram_wdata_o}, 64'd0);
    resetn = 1'b1;

    // Single push, drained two edges after it was accepted
    cycle(1'b1, 2'b01, 4'hF, 8'h10, 2'd1, 32'hDEAD_BEEF, 1'b0);
    fwd("single_fwd", 2'b01, 8'h10, 2'd1, 4'hF, 32'hDEAD_BEEF);
    idle(1'b0);
    check("single_data", 64'(ram_wdata_o), 64'hDEAD_BEEF);
    idle(1'b0);

    // Fill with busy RAM, overflow push dropped, then drain in order
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 2'b10, 4'hF, 8'(8'h40 + i), 2'(i), 32'h1000_0000 + i, 1'b1);
    check("fill_full", 64'(full_o), 64'd1);
    cycle(1'b1, 2'b01, 4'hF, 8'h99, 2'd3, 32'hBAD0_BAD0, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b0);
    check("fill_drained", 64'(exp_q.size()), 64'd0);

    // Coalesce two half-word stores to the same word
    cycle(1'b1, 2'b01, 4'b0011, 8'h33, 2'd2, 32'h0000_AAAA, 1'b1);
    cycle(1'b1, 2'b01, 4'b1100, 8'h33, 2'd2, 32'hBBBB_0000, 1'b1);
    fwd("coal_fwd", 2'b01, 8'h33, 2'd2, 4'hF, 32'hBBBB_AAAA);
    idle(1'b0);
    check("coal_wen", 64'(ram_wen_o), 64'hF);
    check("coal_data", 64'(ram_wdata_o), 64'hBBBB_AAAA);
    idle(1'b0);

    // Youngest-wins forwarding across a different-key store in between
    cycle(1'b1, 2'b01, 4'b0001, 8'h20, 2'd0, 32'h0000_0011, 1'b1);
    cycle(1'b1, 2'b10, 4'b1111, 8'h20, 2'd0, 32'hCAFE_F00D, 1'b1);
    cycle(1'b1, 2'b01, 4'b0001, 8'h20, 2'd0, 32'h0000_0022, 1'b1);
    cycle(1'b1, 2'b01, 4'b0110, 8'h44, 2'd2, 32'hFF77_66FF, 1'b1);
    for (int i = 0; i < 6; i++)
      fwd($sformatf("fwd_vec%0d", i), vt[i].way, vt[i].index, vt[i].offset, vt[i].mask, vt[i].data);
    // Oldest store now in the RAM command register; younger queued store still wins
    idle(1'b0);
    fwd("fwd_inflight_old", 2'b01, 8'h20, 2'd0, 4'b0001, 32'h0000_0022);
    for (int i = 0; i < 4; i++) idle(1'b0);

    // Forwarding from the in-flight command alone
    cycle(1'b1, 2'b01, 4'hF, 8'h30, 2'd2, 32'h1234_5678, 1'b1);
    idle(1'b0);
    fwd("fwd_inflight", 2'b01, 8'h30, 2'd2, 4'hF, 32'h1234_5678);
    idle(1'b0);
    fwd("fwd_retired", 2'b01, 8'h30, 2'd2, 4'h0, 32'h0);

    // Same key as the sole entry while it drains: must become a new entry
    cycle(1'b1, 2'b10, 4'b0001, 8'h55, 2'd1, 32'h0000_00A1, 1'b1);
    cycle(1'b1, 2'b10, 4'b0010, 8'h55, 2'd1, 32'h0000_B200, 1'b0);
    idle(1'b0);
    check("nocoal_wen", 64'(ram_wen_o), 64'b0010);
    idle(1'b0);

    // Push and pop together at count 2, then at count 4 (push dropped)
    cycle(1'b1, 2'b01, 4'hF, 8'h61, 2'd0, 32'h6100_0001, 1'b1);
    cycle(1'b1, 2'b01, 4'hF, 8'h62, 2'd0, 32'h6200_0002, 1'b1);
    cycle(1'b1, 2'b01, 4'hF, 8'h63, 2'd0, 32'h6300_0003, 1'b0);
    cycle(1'b1, 2'b01, 4'hF, 8'h64, 2'd0, 32'h6400_0004, 1'b1);
    cycle(1'b1, 2'b01, 4'hF, 8'h65, 2'd0, 32'h6500_0005, 1'b1);
    check("pp_full", 64'(full_o), 64'd1);
    cycle(1'b1, 2'b01, 4'hF, 8'h66, 2'd0, 32'h6600_0006, 1'b0);
    check("pp_full_drop", 64'(full_o), 64'd0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    check("pp_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 2'b10, 4'hF, 8'(8'h70 + i), 2'd0, 32'h7000_0000 + i, 1'b1);
    idle(1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_ram_en", 64'(ram_en_o), 64'd0);
    check("mid_rst_empty", 64'(empty_o), 64'd1);
    check("mid_rst_wdata", 64'(ram_wdata_o), 64'd0);
    model_reset();
    @(posedge clk);
    #3;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) idle(1'b0);
    fwd("post_rst_fwd", 2'b10, 8'h71, 2'd0, 4'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
